// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/sequencing unit for the 4-bit CPU.
// Fetches 8-bit instructions from program ROM in a two-state FETCH/EXEC
// loop. It decodes them into ALU operand select, immediate and register
// write enables. It also owns the program counter and the architectural
// carry flag.
module instr_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rom_addr,
  output logic       rom_req,
  input  logic       rom_ready,
  input  logic [7:0] rom_data,
  input  logic       carry_in,
  output logic [1:0] src_sel,
  output logic [3:0] imm_out,
  output logic       we_a,
  output logic       we_b,
  output logic       we_out,
  output logic       c_flag
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [1:0] SRC_A    = 2'b00;
  localparam logic [1:0] SRC_B    = 2'b01;
  localparam logic [1:0] SRC_IN   = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q;
  // Operand select and immediate are held after EXEC so that the ALU carry
  // register keeps recomputing the same carry through the whole fetch.
  logic [1:0] src_hold_q;
  logic [3:0] imm_hold_q;

  logic [1:0] dec_src;
  logic       dec_we_a, dec_we_b, dec_we_out;
  logic       dec_jmp, dec_jnc;

  assign rom_addr = pc_q;

  // Opcode decode of the instruction register.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case statement, so a missing branch can never infer a latch.
    dec_src    = SRC_ZERO;
    dec_we_a   = 1'b0;
    dec_we_b   = 1'b0;
    dec_we_out = 1'b0;
    dec_jmp    = 1'b0;
    dec_jnc    = 1'b0;
    unique case (ir_q[7:4])
      4'b0000: begin dec_src = SRC_A;    dec_we_a   = 1'b1; end // ADD A,Im
      4'b0101: begin dec_src = SRC_B;    dec_we_b   = 1'b1; end // ADD B,Im
      4'b0011: begin dec_src = SRC_ZERO; dec_we_a   = 1'b1; end // MOV A,Im
      4'b0111: begin dec_src = SRC_ZERO; dec_we_b   = 1'b1; end // MOV B,Im
      4'b0001: begin dec_src = SRC_B;    dec_we_a   = 1'b1; end // MOV A,B
      4'b0100: begin dec_src = SRC_A;    dec_we_b   = 1'b1; end // MOV B,A
      4'b0010: begin dec_src = SRC_IN;   dec_we_a   = 1'b1; end // IN A
      4'b0110: begin dec_src = SRC_IN;   dec_we_b   = 1'b1; end // IN B
      4'b1001: begin dec_src = SRC_B;    dec_we_out = 1'b1; end // OUT B
      4'b1011: begin dec_src = SRC_ZERO; dec_we_out = 1'b1; end // OUT Im
      4'b1111: dec_jmp = 1'b1;                                  // JMP Im
      4'b1110: dec_jnc = 1'b1;                                  // JNC Im
      default: ;                                                // NOP
    endcase
  end

  // Next-state logic and ROM/ALU/register-file control outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rom_req = 1'b0;
    src_sel = src_hold_q;
    imm_out = imm_hold_q;
    we_a    = 1'b0;
    we_b    = 1'b0;
    we_out  = 1'b0;
    unique case (state_q)
      FETCH: begin
        rom_req = 1'b1;
        if (rom_ready) state_d = EXEC;
      end
      EXEC: begin
        src_sel = dec_src;
        imm_out = ir_q[3:0];
        // A reset landing on EXEC discards the in-flight instruction, so
        // its register write must not reach the register file.
        we_a    = dec_we_a   & ~reset;
        we_b    = dec_we_b   & ~reset;
        we_out  = dec_we_out & ~reset;
        if (dec_jmp || (dec_jnc && !c_flag)) pc_d = ir_q[3:0];
        else                                 pc_d = pc_q + 4'd1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State, PC, instruction register, carry flag and held operand registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= 4'd0;
      ir_q       <= 8'h00;
      c_flag     <= 1'b0;
      src_hold_q <= SRC_ZERO;
      imm_hold_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == FETCH && rom_ready) begin
        ir_q   <= rom_data;
        c_flag <= carry_in;
      end
      if (state_q == EXEC) begin
        src_hold_q <= src_sel;
        imm_hold_q <= imm_out;
      end
    end
  end

endmodule
